// File: rtl/fir_filter_prog.sv
// Run-time programmable transposed-form FIR filter with a coefficient write port,
// a valid-qualified sample path, and rounded, saturated registered output.
module fir_filter_prog #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned NTAPS  = 4,
    parameter int unsigned ACC_W  = DATA_W + COEF_W + $clog2(NTAPS),
    parameter int unsigned OUT_W  = 16,
    parameter int unsigned SHIFT  = 0
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     Coef_we,
    input  logic [$clog2(NTAPS)-1:0] Coef_addr,
    input  logic [COEF_W-1:0]        Coef_wdata,
    input  logic                     Flush,
    input  logic                     In_valid,
    input  logic [DATA_W-1:0]        Xin,
    output logic                     Out_valid,
    output logic [OUT_W-1:0]         Yout,
    output logic                     Sat_flag
);

    localparam int unsigned PROD_W = DATA_W + COEF_W;
    // One extra bit so the rounding offset can never wrap the accumulator.
    localparam int unsigned EXT_W  = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] RND     = EXT_W'((64'd1 << SHIFT) >> 1);
    localparam logic signed [EXT_W-1:0] OUT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] OUT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [COEF_W-1:0] coef_q  [NTAPS];
    logic signed [COEF_W-1:0] coef_d  [NTAPS];
    logic signed [ACC_W-1:0]  state_q [NTAPS-1:1];
    logic signed [ACC_W-1:0]  state_d [NTAPS-1:1];

    logic signed [PROD_W-1:0] prod_c [NTAPS];
    logic signed [ACC_W-1:0]  term_c [NTAPS];
    logic signed [ACC_W-1:0]  full_c;
    logic signed [EXT_W-1:0]  rnd_c;
    logic signed [EXT_W-1:0]  shf_c;
    logic signed [OUT_W-1:0]  sat_val_c;
    logic                     clip_c;

    logic [OUT_W-1:0] yout_q, yout_d;
    logic             out_valid_q, out_valid_d;
    logic             sat_q, sat_d;

    // Full-precision products, sign-extended to the accumulator width.
    always_comb begin
        for (int unsigned k = 0; k < NTAPS; k++) begin
            prod_c[k] = PROD_W'(coef_q[k]) * PROD_W'($signed(Xin));
            term_c[k] = ACC_W'(prod_c[k]);
        end
    end

    // Round half up, arithmetic shift, then clip to the output range.
    always_comb begin
        full_c    = term_c[0] + state_q[1];
        rnd_c     = EXT_W'(full_c) + RND;
        shf_c     = rnd_c >>> SHIFT;
        clip_c    = 1'b0;
        sat_val_c = OUT_W'(shf_c);
        if (shf_c > OUT_MAX) begin
            clip_c    = 1'b1;
            sat_val_c = OUT_W'(OUT_MAX);
        end else if (shf_c < OUT_MIN) begin
            clip_c    = 1'b1;
            sat_val_c = OUT_W'(OUT_MIN);
        end
    end

    // Next-state: coefficient writes, flush, and the transposed delay line.
    always_comb begin
        coef_d      = coef_q;
        state_d     = state_q;
        yout_d      = yout_q;
        sat_d       = sat_q;
        out_valid_d = 1'b0;

        for (int unsigned k = 0; k < NTAPS; k++) begin
            if (Coef_we && (32'(Coef_addr) == k)) begin
                coef_d[k] = $signed(Coef_wdata);
            end
        end

        if (Flush) begin
            for (int unsigned k = 1; k < NTAPS; k++) begin
                state_d[k] = '0;
            end
        end else if (In_valid) begin
            state_d[NTAPS-1] = term_c[NTAPS-1];
            for (int unsigned k = 1; k < NTAPS - 1; k++) begin
                state_d[k] = term_c[k] + state_q[k+1];
            end
            yout_d      = sat_val_c;
            sat_d       = clip_c;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            coef_q      <= '{default: '0};
            state_q     <= '{default: '0};
            yout_q      <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            coef_q      <= coef_d;
            state_q     <= state_d;
            yout_q      <= yout_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
        end
    end

    assign Yout      = yout_q;
    assign Out_valid = out_valid_q;
    assign Sat_flag  = sat_q;

endmodule

// File: tb/tb_fir_filter_prog.sv
// Directed bench for fir_filter_prog: default build, a SHIFT=2 build and a 3-tap build
// share one stimulus bus; expected outputs are hand-computed.
module tb_fir_filter_prog;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              coef_we;
    logic [1:0]        coef_addr;
    logic [7:0]        coef_wdata;
    logic              flush;
    logic              in_valid;
    logic [7:0]        xin;

    logic              ov, ov_sh, ov3;
    logic signed [15:0] yout, yout_sh, yout3;
    logic              sat, sat_sh, sat3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fir_filter_prog u_dut (
        .Clk(clk), .Rst_n(rst_n), .Coef_we(coef_we), .Coef_addr(coef_addr),
        .Coef_wdata(coef_wdata), .Flush(flush), .In_valid(in_valid), .Xin(xin),
        .Out_valid(ov), .Yout(yout), .Sat_flag(sat)
    );

    fir_filter_prog #(.SHIFT(2)) u_dut_sh (
        .Clk(clk), .Rst_n(rst_n), .Coef_we(coef_we), .Coef_addr(coef_addr),
        .Coef_wdata(coef_wdata), .Flush(flush), .In_valid(in_valid), .Xin(xin),
        .Out_valid(ov_sh), .Yout(yout_sh), .Sat_flag(sat_sh)
    );

    fir_filter_prog #(.NTAPS(3)) u_dut3 (
        .Clk(clk), .Rst_n(rst_n), .Coef_we(coef_we), .Coef_addr(coef_addr),
        .Coef_wdata(coef_wdata), .Flush(flush), .In_valid(in_valid), .Xin(xin),
        .Out_valid(ov3), .Yout(yout3), .Sat_flag(sat3)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        coef_we    = 1'b1;
        coef_addr  = 2'(a);
        coef_wdata = 8'(d);
        cyc();
        coef_we    = 1'b0;
    endtask

    task automatic load(input int h0, input int h1, input int h2, input int h3);
        wr(0, h0);
        wr(1, h1);
        wr(2, h2);
        wr(3, h3);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
    endtask

    task automatic push(input int x);
        in_valid = 1'b1;
        xin      = 8'(x);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (yout !== 16'sd0) begin bad++; $display("FAIL reset_yout: got %0d expected 0", yout); end
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL reset_ov: got %b expected 0", ov); end
        total++; if (sat !== 1'b0) begin bad++; $display("FAIL reset_sat: got %b expected 0", sat); end
        rst_n = 1'b1;
        cyc();
        push(100);
        total++; if (ov !== 1'b1) begin bad++; $display("FAIL reset_zero_h_ov: got %b expected 1", ov); end
        total++; if (yout !== 16'sd0) begin bad++; $display("FAIL reset_zero_h: got %0d expected 0", yout); end
    endtask

    task automatic test_impulse();
        int exp_y[5] = '{-2, -1, 3, 4, 0};
        int x_in[5]  = '{1, 0, 0, 0, 0};
        load(-2, -1, 3, 4);
        do_flush();
        for (int i = 0; i < 5; i++) begin
            push(x_in[i]);
            total++; if (ov !== 1'b1) begin bad++; $display("FAIL impulse_ov[%0d]: got %b expected 1", i, ov); end
            total++; if (yout !== 16'(exp_y[i])) begin bad++; $display("FAIL impulse_y[%0d]: got %0d expected %0d", i, yout, exp_y[i]); end
        end
        cyc();
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL impulse_ov_idle: got %b expected 0", ov); end
    endtask

    task automatic test_gaps();
        int exp_y[4] = '{-10, -15, 0, 20};
        do_flush();
        for (int i = 0; i < 4; i++) begin
            push(5);
            total++; if (ov !== 1'b1 || yout !== 16'(exp_y[i])) begin bad++; $display("FAIL gap_valid[%0d]: got ov=%b y=%0d expected ov=1 y=%0d", i, ov, yout, exp_y[i]); end
            xin = 8'd77;
            cyc();
            total++; if (ov !== 1'b0 || yout !== 16'(exp_y[i])) begin bad++; $display("FAIL gap_hold[%0d]: got ov=%b y=%0d expected ov=0 y=%0d", i, ov, yout, exp_y[i]); end
        end
    endtask

    task automatic test_saturation();
        load(-128, -128, -128, -128);
        do_flush();
        push(-128);
        total++; if (yout !== 16'sd16384 || sat !== 1'b0) begin bad++; $display("FAIL sat_first: got y=%0d sat=%b expected y=16384 sat=0", yout, sat); end
        push(-128);
        push(-128);
        push(-128);
        total++; if (yout !== 16'sd32767 || sat !== 1'b1) begin bad++; $display("FAIL sat_pos: got y=%0d sat=%b expected y=32767 sat=1", yout, sat); end
        push(127);
        push(127);
        total++; if (yout !== 16'sd256 || sat !== 1'b0) begin bad++; $display("FAIL sat_clear: got y=%0d sat=%b expected y=256 sat=0", yout, sat); end
        push(127);
        total++; if (yout !== -16'sd32384 || sat !== 1'b0) begin bad++; $display("FAIL sat_near: got y=%0d sat=%b expected y=-32384 sat=0", yout, sat); end
        push(127);
        total++; if (yout !== -16'sd32768 || sat !== 1'b1) begin bad++; $display("FAIL sat_neg: got y=%0d sat=%b expected y=-32768 sat=1", yout, sat); end
    endtask

    task automatic test_rounding();
        int x_in[6]  = '{6, -6, 2, -2, 5, -5};
        int exp_y[6] = '{2, -1, 1, 0, 1, -1};
        load(1, 0, 0, 0);
        do_flush();
        for (int i = 0; i < 6; i++) begin
            push(x_in[i]);
            total++; if (yout_sh !== 16'(exp_y[i]) || sat_sh !== 1'b0) begin bad++; $display("FAIL round[%0d]: got y=%0d sat=%b expected y=%0d sat=0", i, yout_sh, sat_sh, exp_y[i]); end
            total++; if (yout !== 16'(x_in[i])) begin bad++; $display("FAIL round_noshift[%0d]: got %0d expected %0d", i, yout, x_in[i]); end
        end
    endtask

    task automatic test_flush_coef();
        load(-2, -1, 3, 4);
        do_flush();
        push(1);
        push(0);
        total++; if (yout !== -16'sd1) begin bad++; $display("FAIL flush_pre: got %0d expected -1", yout); end
        flush    = 1'b1;
        in_valid = 1'b1;
        xin      = 8'd9;
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        total++; if (ov !== 1'b0 || yout !== -16'sd1) begin bad++; $display("FAIL flush_drop: got ov=%b y=%0d expected ov=0 y=-1", ov, yout); end
        push(1);
        total++; if (yout !== -16'sd2) begin bad++; $display("FAIL flush_clear: got %0d expected -2", yout); end
        coef_we    = 1'b1;
        coef_addr  = 2'd0;
        coef_wdata = 8'd7;
        in_valid   = 1'b1;
        xin        = 8'd1;
        cyc();
        coef_we    = 1'b0;
        in_valid   = 1'b0;
        total++; if (yout !== -16'sd3) begin bad++; $display("FAIL race_old: got %0d expected -3", yout); end
        push(1);
        total++; if (yout !== 16'sd9) begin bad++; $display("FAIL race_new: got %0d expected 9", yout); end
    endtask

    task automatic test_addr_range();
        int exp_y[4] = '{7, -1, 3, 0};
        do_flush();
        wr(3, 50);
        for (int i = 0; i < 4; i++) begin
            push(i == 0 ? 1 : 0);
            total++; if (yout3 !== 16'(exp_y[i])) begin bad++; $display("FAIL addr_oob[%0d]: got %0d expected %0d", i, yout3, exp_y[i]); end
        end
        total++; if (yout !== 16'sd50) begin bad++; $display("FAIL addr_top: got %0d expected 50", yout); end
    endtask

    task automatic test_reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (yout !== 16'sd0 || ov !== 1'b0 || sat !== 1'b0) begin bad++; $display("FAIL reset_mid: got y=%0d ov=%b sat=%b expected 0/0/0", yout, ov, sat); end
        cyc();
        rst_n = 1'b1;
        push(100);
        total++; if (yout !== 16'sd0 || ov !== 1'b1) begin bad++; $display("FAIL reset_mid_h: got y=%0d ov=%b expected y=0 ov=1", yout, ov); end
        wr(0, 1);
        push(3);
        total++; if (yout !== 16'sd3) begin bad++; $display("FAIL reset_mid_hist: got %0d expected 3", yout); end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        coef_we    = 1'b0;
        coef_addr  = 2'd0;
        coef_wdata = 8'd0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        xin        = 8'd0;
        #12;
        test_reset();
        test_impulse();
        test_gaps();
        test_saturation();
        test_rounding();
        test_flush_coef();
        test_addr_range();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
